// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator: sync, blanking, beam position, strobes, frame counter.
// All outputs registered from the next beam position (0 latency vs hpos/vpos); pix_en=0 holds everything but strobes.
module vga_timing_gen #(
  parameter int   H_DISPLAY  = 640,
  parameter int   H_FRONT    = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BACK     = 48,
  parameter int   V_DISPLAY  = 480,
  parameter int   V_BOTTOM   = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_TOP      = 33,
  parameter logic H_SYNC_POL = 1'b0,
  parameter logic V_SYNC_POL = 1'b0,
  parameter int   POS_W      = 10,
  parameter int   FRAME_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_en,
  input  logic               restart,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic [POS_W-1:0]   hpos,
  output logic [POS_W-1:0]   vpos,
  output logic               h_blank,
  output logic               v_blank,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

  localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_TOTAL - 1);
  localparam logic [POS_W-1:0] H_DISP   = POS_W'(H_DISPLAY);
  localparam logic [POS_W-1:0] V_DISP   = POS_W'(V_DISPLAY);
  localparam logic [POS_W-1:0] HS_BEG   = POS_W'(H_DISPLAY + H_FRONT);
  localparam logic [POS_W-1:0] HS_END   = POS_W'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [POS_W-1:0] VS_BEG   = POS_W'(V_DISPLAY + V_BOTTOM);
  localparam logic [POS_W-1:0] VS_END   = POS_W'(V_DISPLAY + V_BOTTOM + V_SYNC);

  if (H_TOTAL > (2 ** POS_W) || V_TOTAL > (2 ** POS_W)) begin : g_pos_w_check
    $error("POS_W too small for H_TOTAL/V_TOTAL");
  end

  logic [POS_W-1:0] next_h;
  logic [POS_W-1:0] next_v;
  logic             next_in_hs;
  logic             next_in_vs;
  logic             next_origin;

  always_comb begin
    next_h = hpos;
    next_v = vpos;
    if (restart) begin
      next_h = '0;
      next_v = '0;
    end else if (hpos == H_LAST) begin
      next_h = '0;
      next_v = (vpos == V_LAST) ? '0 : vpos + POS_W'(1);
    end else begin
      next_h = hpos + POS_W'(1);
    end
    next_in_hs  = (next_h >= HS_BEG) && (next_h < HS_END);
    next_in_vs  = (next_v >= VS_BEG) && (next_v < VS_END);
    next_origin = (next_h == '0) && (next_v == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos        <= '0;
      vpos        <= '0;
      hsync       <= ~H_SYNC_POL;
      vsync       <= ~V_SYNC_POL;
      display_on  <= 1'b1;
      h_blank     <= 1'b0;
      v_blank     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else if (pix_en) begin
      hpos        <= next_h;
      vpos        <= next_v;
      hsync       <= next_in_hs ? H_SYNC_POL : ~H_SYNC_POL;
      vsync       <= next_in_vs ? V_SYNC_POL : ~V_SYNC_POL;
      display_on  <= (next_h < H_DISP) && (next_v < V_DISP);
      h_blank     <= (next_h >= H_DISP);
      v_blank     <= (next_v >= V_DISP);
      line_start  <= (next_h == '0);
      frame_start <= next_origin;
      // A restart re-syncs the beam but is not a completed frame.
      if (next_origin && !restart) begin
        frame_count <= frame_count + FRAME_W'(1);
      end
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule
